// File: rtl/audio_mix_i2s.sv
// Mixes the music and effect samples with saturation and streams the result
// to the codec DAC as a left-justified stereo frame, one mono word per slot.
module audio_mix_i2s #(
  parameter int HALF_BCLK = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic [15:0] sample1,
  input  logic [15:0] sample2,
  input  logic        eff_en,
  input  logic [1:0]  vol_shift,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        data_over
);

  localparam int CW = (HALF_BCLK > 2) ? $clog2(HALF_BCLK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_BCLK - 1);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t             state;
  logic [CW-1:0]      bclk_cnt;
  logic [4:0]         bit_idx;
  logic [15:0]        word;

  logic signed [15:0] eff_val;
  logic signed [16:0] sum;
  logic [15:0]        mix;
  logic [4:0]         next_idx;
  logic               toggle;
  logic               latch_now;

  // Disagreeing top two sum bits mean the 17-bit result left 16-bit range.
  always_comb begin
    eff_val = eff_en ? ($signed(sample2) >>> vol_shift) : 16'sd0;
    sum     = {sample1[15], sample1} + {eff_val[15], eff_val};
    mix     = sum[15:0];
    if (sum[16:15] == 2'b01)
      mix = 16'h7FFF;
    else if (sum[16:15] == 2'b10)
      mix = 16'h8000;
  end

  assign next_idx  = bit_idx + 5'd1;
  assign toggle    = (bclk_cnt == CNT_LAST);
  assign latch_now = (state == START) ||
                     ((state == RUN) && toggle && AUD_BCLK && (bit_idx == 5'd31));

  // Data and LRCK only move on BCLK falling toggles, so they are stable at
  // every rising edge the codec samples on.
  always_ff @(posedge Clk) begin
    if (Reset || !enable) begin
      state       <= IDLE;
      bclk_cnt    <= '0;
      bit_idx     <= '0;
      word        <= '0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
      data_over   <= 1'b0;
    end else begin
      data_over <= 1'b0;
      if (state == IDLE) begin
        state <= START;
      end else if (latch_now) begin
        state       <= RUN;
        word        <= mix;
        bit_idx     <= '0;
        AUD_DACLRCK <= 1'b1;
        AUD_DACDAT  <= mix[15];
        bclk_cnt    <= '0;
        AUD_BCLK    <= 1'b0;
        data_over   <= 1'b1;
      end else if (state == RUN) begin
        if (toggle) begin
          bclk_cnt <= '0;
          AUD_BCLK <= ~AUD_BCLK;
          if (AUD_BCLK) begin
            bit_idx     <= next_idx;
            AUD_DACLRCK <= ~next_idx[4];
            AUD_DACDAT  <= word[~next_idx[3:0]];
          end
        end else begin
          bclk_cnt <= bclk_cnt + 1'b1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_audio_mix_i2s.sv
// Scoreboard bench for audio_mix_i2s: expected mixed words are queued when
// inputs are driven and popped when the serialized frame is captured.
module tb_audio_mix_i2s;

  logic        Clk = 1'b0;
  logic        Reset, enable, eff_en;
  logic [15:0] sample1, sample2;
  logic [1:0]  vol_shift;
  logic        bclk, lrck, dat, dover;
  logic        reset4, enable4;
  logic        bclk4, lrck4, dat4, dover4;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          t0;
  logic [15:0] exp_q[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  audio_mix_i2s #(.HALF_BCLK(16)) dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .sample1(sample1), .sample2(sample2),
    .eff_en(eff_en), .vol_shift(vol_shift), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck),
    .AUD_DACDAT(dat), .data_over(dover)
  );

  audio_mix_i2s #(.HALF_BCLK(4)) dut4 (
    .Clk(Clk), .Reset(reset4), .enable(enable4), .sample1(sample1), .sample2(sample2),
    .eff_en(eff_en), .vol_shift(vol_shift), .AUD_BCLK(bclk4), .AUD_DACLRCK(lrck4),
    .AUD_DACDAT(dat4), .data_over(dover4)
  );

  function automatic logic [15:0] model_mix(input logic [15:0] a, input logic [15:0] b,
                                            input bit ef, input logic [1:0] sh);
    int ai, bi, s;
    ai = int'($signed(a));
    bi = ef ? (int'($signed(b)) >>> sh) : 0;
    s  = ai + bi;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_dover(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (dover) seen = 1'b1;
    end
  endtask

  task automatic capture(output logic [31:0] bits, output logic [31:0] lr, output int got);
    logic prev;
    prev = bclk;
    got  = 0;
    bits = '0;
    lr   = '0;
    for (int i = 0; i < 1100 && got < 32; i++) begin
      tick();
      if (bclk && !prev) begin
        bits = {bits[30:0], dat};
        lr   = {lr[30:0], lrck};
        got++;
      end
      prev = bclk;
    end
  endtask

  task automatic start_dut(output bit seen);
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    wait_dover(4, seen);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({bclk, lrck, dat, dover} !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %b expected 0000", i, {bclk, lrck, dat, dover});
      end
    end
    Reset = 1'b0;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_start();
    sample1 = 16'hA5C3;
    sample2 = 16'h0000;
    eff_en = 1'b0;
    vol_shift = 2'd0;
    exp_q.push_back(16'hA5C3);
    enable = 1'b1;
    tick();
    n_checks++;
    if ({bclk, lrck, dat, dover} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL start_cycle1: got %b expected 0000", {bclk, lrck, dat, dover});
    end
    tick();
    t0 = cyc;
    n_checks++;
    if ({dover, lrck, dat, bclk} !== 4'b1110) begin
      n_fail++;
      $display("[TB] FAIL start_latch: dover/lrck/dat/bclk got %b expected 1110", {dover, lrck, dat, bclk});
    end
    tick();
    n_checks++;
    if (dover !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_pulse_width: data_over got %b expected 0", dover);
    end
  endtask

  task automatic test_serialization();
    logic [31:0] bits, lr;
    logic [15:0] expw;
    int got;
    bit seen;
    capture(bits, lr, got);
    expw = exp_q.pop_front();
    n_checks++;
    if (got != 32 || bits !== {expw, expw}) begin
      n_fail++;
      $display("[TB] FAIL serial_word: got %h (%0d bits) expected %h", bits, got, {expw, expw});
    end
    n_checks++;
    if (lr !== 32'hFFFF0000) begin
      n_fail++;
      $display("[TB] FAIL serial_lrck: got %h expected ffff0000", lr);
    end
    wait_dover(1100, seen);
    n_checks++;
    if (!seen || (cyc - t0) != 1024) begin
      n_fail++;
      $display("[TB] FAIL frame_spacing: got %0d cycles (seen=%0d) expected 1024", cyc - t0, seen);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] s1[2] = '{16'h7530, 16'h8AD0};
    logic [15:0] s2[2] = '{16'h2710, 16'hD8F0};
    logic [15:0] ew[2] = '{16'h7FFF, 16'h8000};
    logic [31:0] bits, lr;
    logic [15:0] expw;
    int got;
    bit seen;
    for (int v = 0; v < 2; v++) begin
      sample1 = s1[v];
      sample2 = s2[v];
      vol_shift = 2'd0;
      eff_en = 1'b1;
      exp_q.push_back(ew[v]);
      start_dut(seen);
      capture(bits, lr, got);
      expw = exp_q.pop_front();
      n_checks++;
      if (!seen || got != 32 || bits !== {expw, expw}) begin
        n_fail++;
        $display("[TB] FAIL sat_word[%0d]: got %h (seen=%0d) expected %h", v, bits, seen, {expw, expw});
      end
    end
  endtask

  task automatic test_attenuation();
    bit          ef[2] = '{1'b1, 1'b0};
    logic [15:0] ew[2] = '{16'h0062, 16'h0064};
    logic [31:0] bits, lr;
    logic [15:0] expw;
    int got;
    bit seen;
    for (int v = 0; v < 2; v++) begin
      sample1 = 16'h0064;
      sample2 = 16'hFFF8;
      vol_shift = 2'd2;
      eff_en = ef[v];
      exp_q.push_back(ew[v]);
      start_dut(seen);
      capture(bits, lr, got);
      expw = exp_q.pop_front();
      n_checks++;
      if (!seen || got != 32 || bits !== {expw, expw}) begin
        n_fail++;
        $display("[TB] FAIL atten_word[%0d]: got %h (seen=%0d) expected %h", v, bits, seen, {expw, expw});
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] bits, lr;
    logic [15:0] expw;
    logic prev;
    int got, fall, pulses;
    bit seen;
    sample1 = 16'h1234;
    eff_en = 1'b0;
    start_dut(seen);
    fall = 0;
    prev = bclk;
    for (int i = 0; i < 400 && fall < 9; i++) begin
      tick();
      if (!bclk && prev) fall++;
      prev = bclk;
    end
    n_checks++;
    if (fall != 9 || lrck !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_setup: falls %0d lrck %b expected 9 and 1", fall, lrck);
    end
    enable = 1'b0;
    tick();
    n_checks++;
    if ({bclk, lrck, dat, dover} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL abort_outputs: got %b expected 0000", {bclk, lrck, dat, dover});
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dover) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_pulse: got %0d pulses expected 0", pulses);
    end
    sample1 = 16'hC35A;
    exp_q.push_back(16'hC35A);
    enable = 1'b1;
    tick();
    n_checks++;
    if (dover !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reenable_early: data_over got %b expected 0", dover);
    end
    tick();
    n_checks++;
    if (dover !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reenable_pulse: data_over got %b expected 1", dover);
    end
    capture(bits, lr, got);
    expw = exp_q.pop_front();
    n_checks++;
    if (got != 32 || bits !== {expw, expw} || lr !== 32'hFFFF0000) begin
      n_fail++;
      $display("[TB] FAIL reenable_frame: got %h lr %h expected %h lr ffff0000", bits, lr, {expw, expw});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s1v[4], s2v[4];
    logic [1:0]  shv[4];
    bit          efv[4];
    logic [31:0] bits, lr;
    logic [15:0] expw;
    int got;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      s1v[i] = 16'($urandom);
      s2v[i] = 16'($urandom);
      shv[i] = 2'($urandom_range(0, 3));
      efv[i] = (i != 2);
    end
    sample1 = s1v[0]; sample2 = s2v[0]; vol_shift = shv[0]; eff_en = efv[0];
    exp_q.push_back(model_mix(s1v[0], s2v[0], efv[0], shv[0]));
    start_dut(seen);
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        sample1 = s1v[i+1]; sample2 = s2v[i+1]; vol_shift = shv[i+1]; eff_en = efv[i+1];
        exp_q.push_back(model_mix(s1v[i+1], s2v[i+1], efv[i+1], shv[i+1]));
      end
      capture(bits, lr, got);
      expw = exp_q.pop_front();
      n_checks++;
      if (got != 32 || bits !== {expw, expw}) begin
        n_fail++;
        $display("[TB] FAIL b2b_word[%0d]: got %h expected %h", i, bits, {expw, expw});
      end
      if (i < 3) begin
        wait_dover(1100, seen);
        n_checks++;
        if (!seen || (cyc - t0) != 1024) begin
          n_fail++;
          $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected 1024", i, cyc - t0);
        end
        t0 = cyc;
      end
    end
  endtask

  task automatic test_param();
    logic prev;
    int r1, r2, t4, nr;
    bit seen;
    reset4 = 1'b0;
    enable4 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (dover4) seen = 1'b1;
    end
    t4 = cyc;
    r1 = 0; r2 = 0; nr = 0;
    prev = bclk4;
    for (int i = 0; i < 40 && nr < 2; i++) begin
      tick();
      if (bclk4 && !prev) begin
        nr++;
        if (nr == 1) r1 = cyc; else r2 = cyc;
      end
      prev = bclk4;
    end
    n_checks++;
    if (!seen || (r1 - t4) != 4 || (r2 - r1) != 8) begin
      n_fail++;
      $display("[TB] FAIL p4_bclk: first rise %0d period %0d expected 4 and 8", r1 - t4, r2 - r1);
    end
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (dover4) seen = 1'b1;
    end
    n_checks++;
    if (!seen || (cyc - t4) != 256) begin
      n_fail++;
      $display("[TB] FAIL p4_spacing: got %0d expected 256", cyc - t4);
    end
    repeat (21) tick();
    reset4 = 1'b1;
    tick();
    n_checks++;
    if ({bclk4, lrck4, dat4, dover4} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL p4_reset: got %b expected 0000", {bclk4, lrck4, dat4, dover4});
    end
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Reset = 1'b1; enable = 1'b0; eff_en = 1'b0;
    sample1 = '0; sample2 = '0; vol_shift = '0;
    reset4 = 1'b1; enable4 = 1'b0;
    test_reset();
    test_start();
    test_serialization();
    test_saturation();
    test_attenuation();
    test_abort();
    test_back_to_back();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_mix_i2s.md
# audio_mix_i2s

Audio output stage sitting directly downstream of the music/sound-effect address sequencers. Each frame it takes the background-music ROM sample and the sound-effect ROM sample, mixes them with saturation, and serializes the result to the codec DAC as a left-justified stereo stream. The same mono word goes to both channels. It emits `data_over`, the per-sample advance pulse that the address sequencers consume.

## Interface
Parameters:
- `HALF_BCLK`, default 16: Clk cycles per BCLK half-period. Must be ≥ 2. Frame = 64·HALF_BCLK Clk cycles, i.e. 1024 cycles, 48.8 kHz at 50 MHz.

Ports:
- `Clk` in 1: system clock. One clock domain.
- `Reset` in 1: synchronous, active-high.
- `enable` in 1: codec configured (driven by INIT_FINISH). Low holds the block idle.
- `sample1` in 16: signed background-music sample.
- `sample2` in 16: signed sound-effect sample.
- `eff_en` in 1: effect enable. 0 makes the effect contribution 0.
- `vol_shift` in 2: arithmetic right-shift applied to `sample2`, range 0–3.
- `AUD_BCLK` out 1: bit clock.
- `AUD_DACLRCK` out 1: 1 = left slot, 0 = right slot.
- `AUD_DACDAT` out 1: serial data, MSB first.
- `data_over` out 1: one-Clk pulse per frame, signalling that a new sample was latched.

## Operation
- States:
  - `IDLE`: all outputs 0, counters 0.
  - `START`: lasts one cycle.
  - `RUN`
- Transitions:
  - `IDLE` → `START` when `enable`=1.
  - `START` → `RUN` always.
  - Any state → `IDLE` when `enable`=0. This takes effect at the next edge, even mid-frame; no frame completion.
- Mix, combinational:
  - e = `eff_en` ? (`sample2` >>> `vol_shift`) : 0. Sign-extended.
  - s = sign-extend17(`sample1`) + sign-extend17(e).
  - mix = s > 32767 → 32767; s < −32768 → −32768; else s[15:0].
- Latch event: occurs in `START`, and in `RUN` on the falling toggle when `bit_idx`=31. On a latch event:
  - shift word ← mix
  - `bit_idx` ← 0
  - `AUD_DACLRCK` ← 1
  - `AUD_DACDAT` ← mix[15]
  - `bclk_cnt` ← 0
  - `AUD_BCLK` ← 0
- BCLK generation in `RUN`:
  - `bclk_cnt` counts 0..HALF_BCLK−1 and wraps.
  - At `bclk_cnt`=HALF_BCLK−1, `AUD_BCLK` toggles.
- Falling toggle (BCLK 1→0) with `bit_idx`=b<31:
  - `bit_idx` ← b+1
  - p = (b+1) mod 16
  - `AUD_DACLRCK` ← (b+1<16)
  - `AUD_DACDAT` ← word[15−p]
- No other registers change on rising toggles.
- Data is therefore stable across each BCLK rising edge. Each slot carries word bits 15..0, left slot then right slot.
- `data_over`: registered. High for exactly the one cycle after each latch event.
- Reset, at any time including mid-frame:
  - state `IDLE`
  - `AUD_BCLK`=`AUD_DACLRCK`=`AUD_DACDAT`=0
  - `data_over`=0
  - `bit_idx`=0, `bclk_cnt`=0
  - shift word 0
- `Reset` has priority over `enable`.

## Timing
- `enable` high at edge N → `START` at N+1 → first latch at edge N+2 → `data_over` high during cycle N+2..N+3.
- Latch spacing in steady `RUN`: exactly 64·HALF_BCLK cycles, with no gaps between frames.
- `AUD_BCLK`:
  - First rising toggle occurs HALF_BCLK cycles after a latch.
  - Period is 2·HALF_BCLK.
  - 32 periods per frame.
- `AUD_DACLRCK`: high for 16 BCLK periods, then low for 16. Edges coincide with BCLK falling edges.
- Sample inputs are sampled only at latch events. Upstream updates its ROM address on `data_over`. The sample must settle within one frame.
- `enable` low at edge M → all outputs 0 from M+1.
- Re-enable → starts a fresh frame aligned per the `START` sequence.

## Test plan
- **Reset/start:** hold `Reset` 5 cycles → all outputs 0. Release, raise `enable` at edge N → `data_over` pulses once, high during N+2..N+3. Next pulse exactly 1024 cycles later.
- **Serialization:** `sample1`=16'hA5C3, `eff_en`=0. Capture `AUD_DACDAT` on BCLK rising edges → left slot = A5C3 and right slot = A5C3. LRCK high 16 BCLKs, then low 16.
- **Saturation:**
  - `sample1`=30000, `sample2`=10000, `vol_shift`=0, `eff_en`=1 → word 16'h7FFF.
  - `sample1`=−30000, `sample2`=−10000 → word 16'h8000.
- **Attenuation/enable:**
  - `sample1`=100, `sample2`=−8, `vol_shift`=2 → word 98.
  - Same inputs with `eff_en`=0 → word 100.
- **Mid-frame abort:** drop `enable` at `bit_idx`=9 → all outputs 0 the next cycle, no `data_over`. Re-enable → `data_over` 2 cycles later, then a full left-slot MSB sequence.
- **Parameter:** `HALF_BCLK`=4 → BCLK period 8 cycles, `data_over` spacing 256 cycles. `Reset` asserted mid-`RUN` → all outputs 0 the next cycle.
